// File: rtl/enemy_scheduler.sv
// rtl/enemy_scheduler.sv - enemy slot scheduler and IDLE/RUN/OVER game FSM
// Optional speed-up with score is enabled by defining ENEMY_SPEEDUP_EN.
module enemy_scheduler #(
   parameter int SLOTS     = 3,
   parameter int XW        = 8,
   parameter int SCREEN_X  = 160,
   parameter int MIN_GAP   = 40,
   parameter int SPEED     = 2,
   parameter int SPEED_MAX = 6
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                tick,
   input  logic                start,
   input  logic                togenerate,
   input  logic                hit,
   output logic [SLOTS*XW-1:0] enemy_x,
   output logic [SLOTS-1:0]    enemy_valid,
   output logic [1:0]          state,
   output logic [15:0]         score,
   output logic                spawn_drop
);

   localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam logic [XW-1:0] X_START = XW'(SCREEN_X - 1);
   localparam logic [XW-1:0] X_GAP   = XW'(SCREEN_X - 1 - MIN_GAP);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      OVER = 2'd2
   } state_t;

   state_t          state_r, state_n;
   logic [XW-1:0]   x_r [SLOTS];
   logic [XW-1:0]   x_n [SLOTS];
   logic [XW-1:0]   mx  [SLOTS];
   logic [SLOTS-1:0] v_r, v_n, mv;
   logic [15:0]     score_r, score_n;
   logic            pending, pend_n, pend_eff;
   logic [IW-1:0]   last_idx, last_n, free_idx;
   logic            drop_r, drop_n;
   logic            free_found, gap_ok, spawn;
   logic [15:0]     exits;
   logic [16:0]     score_sum;
   logic [XW-1:0]   step;

`ifdef ENEMY_SPEEDUP_EN
   logic [16:0] step_sum;

   // step grows by one for every 16 points, computed from the pre-tick score
   always_comb begin
      step_sum = 17'(SPEED) + 17'(score_r[15:4]);
      step     = (step_sum > 17'(SPEED_MAX)) ? XW'(SPEED_MAX) : XW'(step_sum);
   end
`else
   assign step = XW'((SPEED > SPEED_MAX) ? SPEED_MAX : SPEED);
`endif

   always_comb begin
      state_n    = state_r;
      x_n        = x_r;
      v_n        = v_r;
      score_n    = score_r;
      pend_n     = pending;
      last_n     = last_idx;
      drop_n     = 1'b0;
      mx         = x_r;
      mv         = v_r;
      exits      = '0;
      free_found = 1'b0;
      free_idx   = '0;
      gap_ok     = 1'b0;
      spawn      = 1'b0;
      score_sum  = '0;
      pend_eff   = pending | togenerate;

      case (state_r)
         IDLE: begin
            if (start) begin
               state_n = RUN;
               for (int i = 0; i < SLOTS; i++) x_n[i] = '0;
               v_n     = '0;
               score_n = '0;
               pend_n  = 1'b0;
            end
         end
         RUN: begin
            if (hit) begin
               state_n = OVER;
               pend_n  = 1'b0;
            end else begin
               if (tick) begin
                  for (int i = 0; i < SLOTS; i++) begin
                     if (v_r[i]) begin
                        if (x_r[i] < step) begin
                           mv[i] = 1'b0;
                           mx[i] = '0;
                           exits = exits + 16'd1;
                        end else begin
                           mx[i] = x_r[i] - step;
                        end
                     end
                  end
                  // lowest free slot after movement, so a slot exiting now is reusable
                  for (int i = 0; i < SLOTS; i++) begin
                     if (!mv[i] && !free_found) begin
                        free_found = 1'b1;
                        free_idx   = IW'(i);
                     end
                  end
                  gap_ok = !mv[last_idx] || (mx[last_idx] <= X_GAP);
                  spawn  = pend_eff && free_found && gap_ok;
                  if (spawn) begin
                     mv[free_idx] = 1'b1;
                     mx[free_idx] = X_START;
                     last_n       = free_idx;
                  end
                  x_n       = mx;
                  v_n       = mv;
                  score_sum = {1'b0, score_r} + {1'b0, exits};
                  score_n   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
               end
               pend_n = pend_eff && !spawn;
               drop_n = togenerate && pending && !spawn;
            end
         end
         OVER: begin
            pend_n = 1'b0;
            if (start) begin
               state_n = RUN;
               for (int i = 0; i < SLOTS; i++) x_n[i] = '0;
               v_n     = '0;
               score_n = '0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r  <= IDLE;
         for (int i = 0; i < SLOTS; i++) x_r[i] <= '0;
         v_r      <= '0;
         score_r  <= '0;
         pending  <= 1'b0;
         last_idx <= '0;
         drop_r   <= 1'b0;
      end else begin
         state_r  <= state_n;
         x_r      <= x_n;
         v_r      <= v_n;
         score_r  <= score_n;
         pending  <= pend_n;
         last_idx <= last_n;
         drop_r   <= drop_n;
      end
   end

   always_comb begin
      enemy_x = '0;
      for (int i = 0; i < SLOTS; i++) enemy_x[i*XW +: XW] = x_r[i];
   end

   assign enemy_valid = v_r;
   assign state       = state_r;
   assign score       = score_r;
   assign spawn_drop  = drop_r;

endmodule

// File: tb/tb_enemy_scheduler.sv
// tb/tb_enemy_scheduler.sv - self-checking bench for enemy_scheduler
module tb_enemy_scheduler;

   localparam int SLOTS = 3, XW = 8, SCREEN_X = 160, MIN_GAP = 40, SPEED = 2, SPEED_MAX = 6;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        tick = 1'b0, start = 1'b0, togenerate = 1'b0, hit = 1'b0;
   logic [23:0] enemy_x;
   logic [2:0]  enemy_valid;
   logic [1:0]  state;
   logic [15:0] score;
   logic        spawn_drop;

   logic        b_tick = 1'b0, b_start = 1'b0, b_gen = 1'b0, b_hit = 1'b0;
   logic [23:0] b_x;
   logic [2:0]  b_valid;
   logic [1:0]  b_state;
   logic [15:0] b_score;
   logic        b_drop;

   int total = 0;
   int bad   = 0;

   int m_state, m_score, m_last;
   int m_x [SLOTS];
   bit m_v [SLOTS];
   bit m_pend, m_drop;

   always #5 clock = ~clock;

   enemy_scheduler #(.SLOTS(SLOTS), .XW(XW), .SCREEN_X(SCREEN_X), .MIN_GAP(MIN_GAP),
                     .SPEED(SPEED), .SPEED_MAX(SPEED_MAX)) dut (
      .clock(clock), .reset(reset), .tick(tick), .start(start), .togenerate(togenerate),
      .hit(hit), .enemy_x(enemy_x), .enemy_valid(enemy_valid), .state(state),
      .score(score), .spawn_drop(spawn_drop));

   // odd screen width so an enemy lands exactly on x=2
   enemy_scheduler #(.SLOTS(SLOTS), .XW(XW), .SCREEN_X(161), .MIN_GAP(MIN_GAP),
                     .SPEED(SPEED), .SPEED_MAX(SPEED_MAX)) u_b (
      .clock(clock), .reset(reset), .tick(b_tick), .start(b_start), .togenerate(b_gen),
      .hit(b_hit), .enemy_x(b_x), .enemy_valid(b_valid), .state(b_state),
      .score(b_score), .spawn_drop(b_drop));

   function automatic int xs(input int i);
      return int'(enemy_x[i*XW +: XW]);
   endfunction

   task automatic model_reset();
      m_state = 0; m_score = 0; m_last = 0; m_pend = 0; m_drop = 0;
      for (int i = 0; i < SLOTS; i++) begin m_x[i] = 0; m_v[i] = 0; end
   endtask

   task automatic model_clear_run();
      m_state = 1; m_score = 0; m_pend = 0;
      for (int i = 0; i < SLOTS; i++) begin m_x[i] = 0; m_v[i] = 0; end
   endtask

   task automatic model_step(input bit t, input bit s, input bit g, input bit h);
      int stp, ex, fi;
      bit pnow, sp;
      m_drop = 0;
      if (m_state == 0) begin
         if (s) model_clear_run();
      end else if (m_state == 2) begin
         m_pend = 0;
         if (s) model_clear_run();
      end else if (h) begin
         m_state = 2;
         m_pend  = 0;
      end else begin
         pnow = m_pend || g;
         sp   = 0;
         if (t) begin
            stp = SPEED;
`ifdef ENEMY_SPEEDUP_EN
            stp = SPEED + m_score / 16;
            if (stp > SPEED_MAX) stp = SPEED_MAX;
`endif
            ex = 0;
            for (int i = 0; i < SLOTS; i++)
               if (m_v[i]) begin
                  if (m_x[i] < stp) begin m_v[i] = 0; m_x[i] = 0; ex++; end
                  else m_x[i] -= stp;
               end
            fi = -1;
            for (int i = 0; i < SLOTS; i++) if (!m_v[i] && fi < 0) fi = i;
            if (pnow && fi >= 0 && (!m_v[m_last] || m_x[m_last] <= SCREEN_X - 1 - MIN_GAP)) begin
               sp = 1; m_v[fi] = 1; m_x[fi] = SCREEN_X - 1; m_last = fi;
            end
            m_score = (m_score + ex > 65535) ? 65535 : m_score + ex;
         end
         m_drop = g && m_pend && !sp;
         m_pend = pnow && !sp;
      end
   endtask

   task automatic cyc(input bit t, input bit s, input bit g, input bit h);
      tick = t; start = s; togenerate = g; hit = h;
      @(posedge clock);
      model_step(t, s, g, h);
      #1;
      tick = 0; start = 0; togenerate = 0; hit = 0;
   endtask

   task automatic bcyc(input bit t, input bit s, input bit g);
      b_tick = t; b_start = s; b_gen = g;
      @(posedge clock);
      #1;
      b_tick = 0; b_start = 0; b_gen = 0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      model_reset();
      total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
      total++; if (enemy_valid !== 3'b000) begin bad++; $display("FAIL reset_valid got=%b exp=000", enemy_valid); end
      total++; if (score !== 16'd0 || enemy_x !== 24'd0 || spawn_drop !== 1'b0) begin
         bad++; $display("FAIL reset_data score=%0d x=%h drop=%b exp all zero", score, enemy_x, spawn_drop); end
      reset = 1'b0;
      cyc(0, 1, 0, 0);
      total++; if (state !== 2'd1) begin bad++; $display("FAIL start_run got=%0d exp=1", state); end
   endtask

   task automatic test_spawn_move();
      cyc(0, 0, 1, 0);
      total++; if (enemy_valid !== 3'b000) begin bad++; $display("FAIL spawn_waits_tick got=%b exp=000", enemy_valid); end
      cyc(1, 0, 0, 0);
      total++; if (enemy_valid !== 3'b001 || xs(0) != 159) begin
         bad++; $display("FAIL spawn_slot0 valid=%b x0=%0d exp valid=001 x0=159", enemy_valid, xs(0)); end
      repeat (10) cyc(1, 0, 0, 0);
      total++; if (xs(0) != 139) begin bad++; $display("FAIL move_10 got=%0d exp=139", xs(0)); end
   endtask

   task automatic test_gap();
      cyc(0, 0, 1, 0);
      repeat (9) cyc(1, 0, 0, 0);
      total++; if (enemy_valid !== 3'b001 || xs(0) != 121) begin
         bad++; $display("FAIL gap_hold valid=%b x0=%0d exp valid=001 x0=121", enemy_valid, xs(0)); end
      cyc(1, 0, 0, 0);
      total++; if (enemy_valid !== 3'b011 || xs(0) != 119 || xs(1) != 159) begin
         bad++; $display("FAIL gap_spawn valid=%b x0=%0d x1=%0d exp 011/119/159", enemy_valid, xs(0), xs(1)); end
   endtask

   task automatic test_exit_score();
      repeat (59) cyc(1, 0, 0, 0);
      total++; if (xs(0) != 1 || score !== 16'd0) begin
         bad++; $display("FAIL pre_exit x0=%0d score=%0d exp x0=1 score=0", xs(0), score); end
      cyc(1, 0, 0, 0);
      total++; if (enemy_valid !== 3'b010 || xs(0) != 0 || xs(1) != 39) begin
         bad++; $display("FAIL exit_free valid=%b x0=%0d x1=%0d exp 010/0/39", enemy_valid, xs(0), xs(1)); end
      total++; if (score !== 16'd1) begin bad++; $display("FAIL exit_score got=%0d exp=1", score); end
   endtask

   task automatic test_collision_restart();
      cyc(1, 0, 0, 1);
      total++; if (state !== 2'd2 || enemy_valid !== 3'b010 || xs(1) != 39 || score !== 16'd1) begin
         bad++; $display("FAIL hit_freeze state=%0d valid=%b x1=%0d score=%0d exp 2/010/39/1",
                         state, enemy_valid, xs(1), score); end
      cyc(1, 0, 1, 0);
      total++; if (state !== 2'd2 || xs(1) != 39 || score !== 16'd1) begin
         bad++; $display("FAIL over_frozen state=%0d x1=%0d score=%0d exp 2/39/1", state, xs(1), score); end
      cyc(0, 1, 0, 0);
      total++; if (state !== 2'd1 || enemy_valid !== 3'b000 || score !== 16'd0) begin
         bad++; $display("FAIL restart state=%0d valid=%b score=%0d exp 1/000/0", state, enemy_valid, score); end
   endtask

   task automatic test_full_drop();
      cyc(1, 0, 1, 0);
      cyc(0, 0, 1, 0);
      repeat (20) cyc(1, 0, 0, 0);
      cyc(0, 0, 1, 0);
      repeat (20) cyc(1, 0, 0, 0);
      total++; if (enemy_valid !== 3'b111 || xs(0) != 79 || xs(1) != 119 || xs(2) != 159) begin
         bad++; $display("FAIL fill valid=%b x=%0d/%0d/%0d exp 111 79/119/159", enemy_valid, xs(0), xs(1), xs(2)); end
      cyc(0, 0, 1, 0);
      total++; if (spawn_drop !== 1'b0) begin bad++; $display("FAIL first_req_no_drop got=%b exp=0", spawn_drop); end
      cyc(0, 0, 1, 0);
      total++; if (spawn_drop !== 1'b1) begin bad++; $display("FAIL drop_pulse got=%b exp=1", spawn_drop); end
      cyc(0, 0, 0, 0);
      total++; if (spawn_drop !== 1'b0) begin bad++; $display("FAIL drop_one_cycle got=%b exp=0", spawn_drop); end
      repeat (40) cyc(1, 0, 0, 0);
      total++; if (enemy_valid !== 3'b111 || xs(0) != 159 || xs(1) != 39 || xs(2) != 79 || score !== 16'd1) begin
         bad++; $display("FAIL reuse valid=%b x=%0d/%0d/%0d score=%0d exp 111 159/39/79 1",
                         enemy_valid, xs(0), xs(1), xs(2), score); end
   endtask

`ifdef ENEMY_SPEEDUP_EN
   task automatic test_speedup();
      int n, j, xb, pre, exp_step;
      cyc(0, 0, 0, 1);
      cyc(0, 1, 0, 0);
      n = 0;
      while (score < 16 && n < 3000) begin cyc(1, 0, 1, 0); n++; end
      total++; if (score < 16) begin bad++; $display("FAIL speedup_timeout score=%0d exp>=16", score); end
      j = -1;
      for (int i = 0; i < SLOTS; i++) if (enemy_valid[i] && xs(i) >= 6 && j < 0) j = i;
      pre = int'(score);
      xb  = (j >= 0) ? xs(j) : 0;
      exp_step = SPEED + pre / 16;
      if (exp_step > SPEED_MAX) exp_step = SPEED_MAX;
      cyc(1, 0, 0, 0);
      total++; if (j < 0 || xs(j) != xb - exp_step) begin
         bad++; $display("FAIL speedup_step slot=%0d got=%0d exp=%0d", j, (j >= 0) ? xs(j) : -1, xb - exp_step); end
   endtask
`endif

   task automatic test_random();
      bit t, s, g, h;
      logic [23:0] ex;
      logic [2:0]  ev;
      int errs;
      cyc(1, 0, 1, 0);
      reset = 1'b1;
      #1;
      total++; if (state !== 2'd0 || enemy_valid !== 3'b000 || score !== 16'd0) begin
         bad++; $display("FAIL async_reset state=%0d valid=%b score=%0d exp 0/000/0", state, enemy_valid, score); end
      @(posedge clock);
      #1;
      reset = 1'b0;
      model_reset();
      errs = 0;
      for (int c = 0; c < 3000; c++) begin
         t = ($urandom_range(0, 99) < 55);
         s = ($urandom_range(0, 99) < 3);
         g = ($urandom_range(0, 99) < 15);
         h = ($urandom_range(0, 199) < 1);
         cyc(t, s, g, h);
         ex = '0; ev = '0;
         for (int i = 0; i < SLOTS; i++) begin ex[i*XW +: XW] = 8'(m_x[i]); ev[i] = m_v[i]; end
         total++;
         if (state !== 2'(m_state) || enemy_x !== ex || enemy_valid !== ev ||
             score !== 16'(m_score) || spawn_drop !== m_drop) begin
            bad++; errs++;
            if (errs <= 10)
               $display("FAIL rand c=%0d state=%0d/%0d x=%h/%h valid=%b/%b score=%0d/%0d drop=%b/%b (got/exp)",
                        c, state, m_state, enemy_x, ex, enemy_valid, ev, score, m_score, spawn_drop, m_drop);
         end
      end
   endtask

   task automatic test_even_exit();
      bcyc(0, 1, 0);
      bcyc(1, 0, 1);
      total++; if (b_valid[0] !== 1'b1 || b_x[7:0] !== 8'd160) begin
         bad++; $display("FAIL b_spawn valid=%b x0=%0d exp 1/160", b_valid[0], b_x[7:0]); end
      repeat (79) bcyc(1, 0, 0);
      total++; if (b_x[7:0] !== 8'd2) begin bad++; $display("FAIL b_at_two got=%0d exp=2", b_x[7:0]); end
      bcyc(1, 0, 0);
      total++; if (b_valid[0] !== 1'b1 || b_x[7:0] !== 8'd0 || b_score !== 16'd0) begin
         bad++; $display("FAIL b_two_stays valid=%b x0=%0d score=%0d exp 1/0/0", b_valid[0], b_x[7:0], b_score); end
      bcyc(1, 0, 0);
      total++; if (b_valid[0] !== 1'b0 || b_score !== 16'd1) begin
         bad++; $display("FAIL b_zero_exits valid=%b score=%0d exp 0/1", b_valid[0], b_score); end
   endtask

   initial begin
      test_reset();
      test_spawn_move();
      test_gap();
      test_exit_score();
      test_collision_restart();
      test_full_drop();
`ifdef ENEMY_SPEEDUP_EN
      test_speedup();
`endif
      test_random();
      test_even_exit();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
